// File: rtl/knn_controller.sv
// ---------------------------------------------------------------------------
// knn_controller
// Sequences one k-nearest-neighbour query. It accepts a command, then forwards
// a reference point followed by cmd_num_points data points from a valid/ready
// word stream to the datapath. It then waits a fixed drain interval and holds
// knn_done until software clears it.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   cmd_start           one-cycle query request (honoured only when idle)
//   cmd_num_points      data points following the reference point (>=1)
//   cmd_k               neighbour count (>=1), presented on knn_k
//   cmd_clear           releases the DONE state
//   s_valid/s_data      input word stream
//   s_ready             stream ready (high while loading or streaming)
//   knn_start           one-cycle pulse on the first LOAD_REF cycle
//   knn_data_valid/knn_data  registered copy of each transferred word
//   knn_k               latched neighbour count
//   knn_done            level, high while in DONE
//   busy                high whenever not idle
//   err                 sticky flag for a rejected command
//   stall_cycles        input-starvation counter (optional, see below)
//
// Optional feature
//   KNN_CTRL_PERF_EN    when defined, stall_cycles counts the cycles spent in
//                       LOAD_REF/STREAM with s_valid low. The counter saturates
//                       and clears on each accepted command. When undefined,
//                       stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module knn_controller #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_DIMENSIONS = 32,
   parameter int DRAIN_CYCLES   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_start,
   input  logic [31:0]           cmd_num_points,
   input  logic [31:0]           cmd_k,
   input  logic                  cmd_clear,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  knn_start,
   output logic                  knn_data_valid,
   output logic [DATA_WIDTH-1:0] knn_data,
   output logic [31:0]           knn_k,
   output logic                  knn_done,
   output logic                  busy,
   output logic                  err,
   output logic [31:0]           stall_cycles
);

   localparam int DIM_W   = (NUM_DIMENSIONS > 1) ? $clog2(NUM_DIMENSIONS) : 1;
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DIM_W-1:0]   DIM_LAST   = DIM_W'(NUM_DIMENSIONS - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_REF = 3'd1,
      STREAM   = 3'd2,
      DRAIN    = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t              state_r;
   state_t              nextState_s;
   logic [DIM_W-1:0]    dimCnt_r;
   logic [31:0]         pointCnt_r;
   logic [DRAIN_W-1:0]  drainCnt_r;
   logic [31:0]         numPoints_r;

   logic                xfer_s;
   logic                cmdOk_s;
   logic                lastDim_s;
   logic                lastPoint_s;
   logic                lastDrain_s;
   logic                knnStartNext_s;
   logic                sReadyNext_s;
   logic                busyNext_s;
   logic                doneNext_s;

   // s_ready is registered and high exactly in LOAD_REF/STREAM, so it doubles
   // as the "accepting words" qualifier.
   assign xfer_s      = s_valid & s_ready;
   assign cmdOk_s     = cmd_start & (cmd_num_points != 32'd0) & (cmd_k != 32'd0);
   assign lastDim_s   = (dimCnt_r == DIM_LAST);
   assign lastPoint_s = (pointCnt_r == (numPoints_r - 32'd1));
   assign lastDrain_s = (drainCnt_r == DRAIN_LAST);

   // Next-state decode for the query sequencer.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE:     nextState_s = cmdOk_s ? LOAD_REF : IDLE;
         LOAD_REF: nextState_s = (xfer_s && lastDim_s) ? STREAM : LOAD_REF;
         STREAM: begin
            if (xfer_s && lastDim_s && lastPoint_s) begin
               nextState_s = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
            end else begin
               nextState_s = STREAM;
            end
         end
         DRAIN:    nextState_s = lastDrain_s ? DONE : DRAIN;
         DONE:     nextState_s = cmd_clear ? IDLE : DONE;
         default:  nextState_s = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so that they can be
   // registered while still lining up with the state they describe.
   always_comb begin
      knnStartNext_s = (state_r == IDLE) && (nextState_s == LOAD_REF);
      sReadyNext_s   = (nextState_s == LOAD_REF) || (nextState_s == STREAM);
      busyNext_s     = (nextState_s != IDLE);
      doneNext_s     = (nextState_s == DONE);
   end

   // State register and registered control outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         knn_start <= 1'b0;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         knn_done  <= 1'b0;
      end else begin
         state_r   <= nextState_s;
         knn_start <= knnStartNext_s;
         s_ready   <= sReadyNext_s;
         busy      <= busyNext_s;
         knn_done  <= doneNext_s;
      end
   end

   // Command latch, error flag, word forwarding and position counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         knn_data_valid <= 1'b0;
         knn_data       <= {DATA_WIDTH{1'b0}};
         knn_k          <= 32'd0;
         numPoints_r    <= 32'd0;
         err            <= 1'b0;
         dimCnt_r       <= {DIM_W{1'b0}};
         pointCnt_r     <= 32'd0;
         drainCnt_r     <= {DRAIN_W{1'b0}};
      end else begin
         knn_data_valid <= xfer_s;
         if (xfer_s) begin
            knn_data <= s_data;
         end

         if ((state_r == IDLE) && cmd_start) begin
            if (cmdOk_s) begin
               numPoints_r <= cmd_num_points;
               knn_k       <= cmd_k;
               err         <= 1'b0;
               dimCnt_r    <= {DIM_W{1'b0}};
               pointCnt_r  <= 32'd0;
            end else begin
               err <= 1'b1;
            end
         end

         // The reference point does not advance the point counter; only wraps
         // while streaming data points do.
         if (xfer_s) begin
            if (lastDim_s) begin
               dimCnt_r <= {DIM_W{1'b0}};
               if (state_r == STREAM) begin
                  pointCnt_r <= pointCnt_r + 32'd1;
               end
            end else begin
               dimCnt_r <= dimCnt_r + DIM_W'(1);
            end
         end

         if (state_r == DRAIN) begin
            drainCnt_r <= drainCnt_r + DRAIN_W'(1);
         end else begin
            drainCnt_r <= {DRAIN_W{1'b0}};
         end
      end
   end

`ifdef KNN_CTRL_PERF_EN
   logic [31:0] stallCnt_r;

   // Starvation counter: cycles the stream was wanted but not offered.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt_r <= 32'd0;
      end else if ((state_r == IDLE) && cmdOk_s) begin
         stallCnt_r <= 32'd0;
      end else if (s_ready && !s_valid && (stallCnt_r != 32'hFFFF_FFFF)) begin
         stallCnt_r <= stallCnt_r + 32'd1;
      end
   end

   assign stall_cycles = stallCnt_r;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_knn_controller.sv
module tb_knn_controller;
   localparam int DW = 32;
   localparam int ND = 4;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_start;
   logic [31:0]   cmd_num_points;
   logic [31:0]   cmd_k;
   logic          cmd_clear;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          knn_start;
   logic          knn_data_valid;
   logic [DW-1:0] knn_data;
   logic [31:0]   knn_k;
   logic          knn_done;
   logic          busy;
   logic          err;
   logic [31:0]   stall_cycles;

   knn_controller #(.DATA_WIDTH(DW), .NUM_DIMENSIONS(ND), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_num_points(cmd_num_points),
      .cmd_k(cmd_k), .cmd_clear(cmd_clear), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .knn_start(knn_start), .knn_data_valid(knn_data_valid),
      .knn_data(knn_data), .knn_k(knn_k), .knn_done(knn_done), .busy(busy),
      .err(err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observed behaviour, sampled on the falling edge.
   logic [DW-1:0] gotQ[$];
   int            gotCyc[$];
   logic [DW-1:0] expQ[$];
   int            startCnt = 0;
   int            startCyc = -1;
   int            doneRise = -1;
   logic          prevDone = 1'b0;

   always @(negedge clk) begin
      if (knn_data_valid) begin
         gotQ.push_back(knn_data);
         gotCyc.push_back(cyc);
      end
      if (knn_start) begin
         startCnt = startCnt + 1;
         startCyc = cyc;
      end
      if (knn_done && !prevDone) doneRise = cyc;
      prevDone = knn_done;
   end

   typedef struct {
      int np;
      int k;
      int stallAt;
      int stallLen;
      bit expErr;
   } qvec_t;

   qvec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearMon();
      gotQ.delete();
      gotCyc.delete();
      expQ.delete();
      startCnt = 0;
      startCyc = -1;
      doneRise = -1;
   endtask

   function automatic int expStall(input int idle);
`ifdef KNN_CTRL_PERF_EN
      return idle;
`else
      return 0 * idle;
`endif
   endfunction

   task automatic issueCmd(input int np, input int k, output int cmdCyc);
      cmdCyc = cyc;
      cmd_start = 1'b1;
      cmd_num_points = np;
      cmd_k = k;
      step();
      cmd_start = 1'b0;
   endtask

   // Offers 'total' words in order. Optional idle gaps are inserted before a word,
   // and an optional stray cmd_start is raised alongside word injAt.
   task automatic streamWords(input int total, input int stallAt, input int stallLen,
                              input bit randStall, input int injAt, output int idle);
      int   guard;
      int   n;
      logic rdy;
      idle = 0;
      for (int i = 0; i < total; i++) begin
         n = 0;
         if (i == stallAt) n = stallLen;
         else if (randStall && ($urandom_range(0, 3) == 0)) n = $urandom_range(1, 3);
         s_valid = 1'b0;
         repeat (n) step();
         idle = idle + n;
         s_data = $urandom;
         s_valid = 1'b1;
         expQ.push_back(s_data);
         if (i == injAt) begin
            cmd_start = 1'b1;
            cmd_num_points = 32'd5;
            cmd_k = 32'd9;
         end
         guard = 0;
         rdy = 1'b0;
         do begin
            @(negedge clk);
            rdy = s_ready;
            step();
            cmd_start = 1'b0;
            guard = guard + 1;
         end while (!rdy && guard < 50);
         if (!rdy) chk("handshake_timeout", 64'd0, 64'd1);
      end
      s_valid = 1'b0;
   endtask

   task automatic finishQuery(input int np, input int k, input int cmdCyc, input int idle);
      int guard;
      int held;
      int n;
      guard = 0;
      while (!knn_done && guard < 200) begin
         step();
         guard = guard + 1;
      end
      chk("done_reached", knn_done, 1);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (knn_done) held = held + 1;
      end
      chk("done_held_10", held, 10);
      chk("word_count", gotQ.size(), (np + 1) * ND);
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) chk("word_data", gotQ[i], expQ[i]);
      chk("start_pulses", startCnt, 1);
      chk("start_cycle", startCyc, cmdCyc + 1);
      if (gotCyc.size() > 0) chk("done_latency", doneRise - gotCyc[gotCyc.size() - 1], DC);
      chk("knn_k", knn_k, k);
      chk("busy_in_done", busy, 1);
      chk("err_low", err, 0);
      chk("stall_cycles", stall_cycles, expStall(idle));
      cmd_clear = 1'b1;
      step();
      cmd_clear = 1'b0;
      chk("clear_busy", busy, 0);
      chk("clear_done", knn_done, 0);
   endtask

   task automatic checkAllZero(input string tag);
      chk({tag, "_knn_start"}, knn_start, 0);
      chk({tag, "_data_valid"}, knn_data_valid, 0);
      chk({tag, "_knn_data"}, knn_data, 0);
      chk({tag, "_knn_k"}, knn_k, 0);
      chk({tag, "_knn_done"}, knn_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_stall"}, stall_cycles, 0);
      chk({tag, "_s_ready"}, s_ready, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cmdCyc;
      int idle;
      int np;
      int k;

      // np, k, stall before word index, stall length, command rejected
      vecs[0] = '{2, 3, -1, 0, 1'b0};
      vecs[1] = '{2, 3,  6, 5, 1'b0};
      vecs[2] = '{0, 3, -1, 0, 1'b1};
      vecs[3] = '{1, 7, -1, 0, 1'b0};
      vecs[4] = '{3, 0, -1, 0, 1'b1};
      vecs[5] = '{1, 1,  0, 2, 1'b0};

      reset = 1'b1;
      cmd_start = 1'b0;
      cmd_num_points = 32'd0;
      cmd_k = 32'd0;
      cmd_clear = 1'b0;
      s_valid = 1'b0;
      s_data = 32'd0;
      repeat (3) step();
      checkAllZero("reset");
      reset = 1'b0;
      step();

      for (int v = 0; v < 6; v++) begin
         clearMon();
         issueCmd(vecs[v].np, vecs[v].k, cmdCyc);
         if (vecs[v].expErr) begin
            chk("bad_cmd_err", err, 1);
            chk("bad_cmd_busy", busy, 0);
            step();
            step();
            chk("bad_cmd_no_start", startCnt, 0);
         end else begin
            chk("cmd_err_cleared", err, 0);
            streamWords((vecs[v].np + 1) * ND, vecs[v].stallAt, vecs[v].stallLen, 1'b0, -1, idle);
            finishQuery(vecs[v].np, vecs[v].k, cmdCyc, idle);
         end
      end

      // A second cmd_start while streaming must not disturb the running query.
      clearMon();
      issueCmd(2, 3, cmdCyc);
      streamWords(12, -1, 0, 1'b0, 7, idle);
      finishQuery(2, 3, cmdCyc, idle);

      // Reset after the sixth word; reset wins over start, clear and handshake.
      clearMon();
      issueCmd(2, 3, cmdCyc);
      streamWords(6, -1, 0, 1'b0, -1, idle);
      reset = 1'b1;
      cmd_start = 1'b1;
      cmd_clear = 1'b1;
      s_valid = 1'b1;
      s_data = $urandom;
      step();
      checkAllZero("midreset");
      reset = 1'b0;
      cmd_start = 1'b0;
      cmd_clear = 1'b0;
      s_valid = 1'b0;
      step();
      chk("post_reset_idle", busy, 0);
      clearMon();
      issueCmd(2, 3, cmdCyc);
      streamWords(12, -1, 0, 1'b0, -1, idle);
      finishQuery(2, 3, cmdCyc, idle);

      // Randomised queries with random input starvation.
      for (int r = 0; r < 6; r++) begin
         np = $urandom_range(1, 4);
         k = $urandom_range(1, 50);
         clearMon();
         issueCmd(np, k, cmdCyc);
         streamWords((np + 1) * ND, -1, 0, 1'b1, -1, idle);
         finishQuery(np, k, cmdCyc, idle);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/knn_controller.md
KNN_CONTROLLER -- requirements
Module: knn_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one dimension value.
REQ-002 Parameter NUM_DIMENSIONS, default 32, words per point (reference point and every data point).
REQ-003 Parameter DRAIN_CYCLES, default 4, idle cycles between the last forwarded word and knn_done.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cmd_start  in  1  one-cycle request to begin a query.
REQ-007 cmd_num_points  in  32  number of data points following the reference point.
REQ-008 cmd_k  in  32  neighbour count for the query.
REQ-009 cmd_clear  in  1  releases DONE state.
REQ-010 s_valid / s_data / s_ready  in / in DATA_WIDTH / out  input word stream, valid-ready handshake.
REQ-011 knn_start  out  1  one-cycle start pulse to the datapath.
REQ-012 knn_data_valid / knn_data  out / out DATA_WIDTH  registered forwarded word.
REQ-013 knn_k  out  32  latched cmd_k.
REQ-014 knn_done  out  1  level, high in DONE.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 err  out  1  sticky illegal-command flag.
REQ-017 stall_cycles  out  32  performance counter (see Configuration).

Function
REQ-018 States: IDLE, LOAD_REF, STREAM, DRAIN, DONE; encoded state held in one register.
REQ-019 IDLE: cmd_start with cmd_num_points>=1 and cmd_k>=1 latches both and clears err, then moves to LOAD_REF on the next edge.
REQ-020 IDLE: cmd_start with cmd_num_points==0 or cmd_k==0 sets err and remains in IDLE.
REQ-021 cmd_start outside IDLE shall be ignored and shall not modify latched values or err.
REQ-022 knn_start is high exactly the first cycle in LOAD_REF.
REQ-023 s_ready is 1 only in LOAD_REF and STREAM; a word transfers when s_valid and s_ready are both high.
REQ-024 Each transfer drives knn_data=s_data and knn_data_valid=1 on the following cycle; otherwise knn_data_valid=0 and knn_data holds.
REQ-025 Dimension counter counts transfers 0..NUM_DIMENSIONS-1 and wraps to 0; point counter increments on each wrap in STREAM.
REQ-026 LOAD_REF exits to STREAM on the transfer with dimension count NUM_DIMENSIONS-1.
REQ-027 STREAM exits to DRAIN on the final transfer of point cmd_num_points-1 (cmd_num_points*NUM_DIMENSIONS words total).
REQ-028 s_valid low in LOAD_REF/STREAM causes no transfer and no counter change; no timeout.
REQ-029 DRAIN lasts exactly DRAIN_CYCLES cycles, then DONE.
REQ-030 DONE holds knn_done=1 until cmd_clear, then IDLE on the next edge; cmd_clear in other states is ignored.
REQ-031 knn_k drives the latched k from acceptance until the next accepted command.

Reset
REQ-032 reset forces IDLE and zeroes all counters, knn_start, knn_data_valid, knn_data, knn_k, knn_done, busy, err, stall_cycles, and s_ready (0) on the next edge, including mid-query.
REQ-033 reset takes priority over cmd_start, cmd_clear, and any handshake in the same cycle.

Configuration
REQ-034 With macro KNN_CTRL_PERF_EN defined, stall_cycles increments once per cycle in LOAD_REF or STREAM with s_valid=0, saturates at 0xFFFFFFFF, and clears on accepted cmd_start.
REQ-035 Without KNN_CTRL_PERF_EN, stall_cycles is constant 0 and no counter logic is built.

Verification (NUM_DIMENSIONS=4, DRAIN_CYCLES=4)
REQ-036 cmd_start with num_points=2, k=3, and continuous s_valid for 12 words -> knn_start pulse 1 cycle after cmd_start, 12 knn_data_valid cycles in order, knn_done high 4 cycles after the last one, knn_k=3.
REQ-037 Same query with s_valid low for 5 cycles mid-STREAM -> word order preserved, total still 12, stall_cycles=5 with the macro and 0 without.
REQ-038 cmd_start with num_points=0 -> err=1, busy=0, no knn_start; then a valid cmd_start -> err=0.
REQ-039 cmd_start repeated during STREAM -> ignored, query completes with the original 12 words.
REQ-040 reset asserted after the 6th word -> next cycle all outputs are 0 and state is IDLE; a new query then runs normally.
REQ-041 In DONE, cmd_clear held low for 10 cycles -> knn_done stays 1; cmd_clear pulse -> IDLE and busy=0 on the next cycle.
